// File: rtl/seq_alu_if.sv
// Request/result bundle between an instruction sequencer and seq_alu.
// A transfer happens on a rising edge where valid && ready; the source holds valid and payload until then.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, res, res_hi, carry, zero, neg, ovf
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, res, res_hi, carry, zero, neg, ovf
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with full flag set: single-edge ADD/SUB/logic/shift ops and a
// WIDTH-step shift-add unsigned multiply, one operation in flight at a time.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_alu_if.slave     bus,
    output logic [1:0]   o_state
);
    localparam int W = WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};
    localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_in_ready;

    logic [W-1:0]    r_res;
    logic [W-1:0]    r_res_hi;
    logic            r_carry;
    logic            r_zero;
    logic            r_neg;
    logic            r_ovf;
    logic            r_out_valid;

    logic [W-1:0]    r_mcand;
    logic [2*W-1:0]  r_prod;
    logic [SHW:0]    r_cnt;

    logic [SHW-1:0]  w_sh;
    logic [W:0]      w_sum;
    logic [W:0]      w_dif;
    logic [W:0]      w_shl;
    logic [W:0]      w_shr;
    logic [W-1:0]    w_res;
    logic            w_c;
    logic            w_v;
    logic [W:0]      w_mul_add;
    logic [2*W-1:0]  w_prod_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = rst_n && (r_state == IDLE);
        case (r_state)
            IDLE: if (bus.in_valid) w_next = (bus.opcode == OP_MUL) ? MUL : DONE;
            MUL:  if (r_cnt == CNT_ONE) w_next = DONE;
            DONE: if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Widened sums/shifts put carry, borrow and shifted-out bit in the extra bit.
    always_comb begin
        w_sh  = bus.b[SHW-1:0];
        w_sum = {1'b0, bus.a} + {1'b0, bus.b};
        w_dif = {1'b0, bus.a} - {1'b0, bus.b};
        w_shl = {1'b0, bus.a} << w_sh;
        w_shr = {bus.a, 1'b0} >> w_sh;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = (bus.a[W-1] == bus.b[W-1]) && (w_sum[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                w_res = w_dif[W-1:0];
                w_c   = w_dif[W];
                w_v   = (bus.a[W-1] != bus.b[W-1]) && (w_dif[W-1] != bus.a[W-1]);
            end
            OP_AND: w_res = bus.a & bus.b;
            OP_OR:  w_res = bus.a | bus.b;
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_SHL: begin
                w_res = w_shl[W-1:0];
                w_c   = w_shl[W];
            end
            OP_SHR: begin
                w_res = w_shr[W:1];
                w_c   = w_shr[0];
            end
            default: ;
        endcase
    end

    // Product register holds {partial high word, remaining multiplier bits}.
    always_comb begin
        w_mul_add  = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_nxt = {w_mul_add, r_prod[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_res_hi    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.opcode == OP_MUL) begin
                            r_mcand <= bus.a;
                            r_prod  <= {{W{1'b0}}, bus.b};
                            r_cnt   <= CNT_LOAD;
                        end else begin
                            r_res       <= w_res;
                            r_res_hi    <= '0;
                            r_carry     <= w_c;
                            r_zero      <= (w_res == '0);
                            r_neg       <= w_res[W-1];
                            r_ovf       <= w_v;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_res       <= w_prod_nxt[W-1:0];
                        r_res_hi    <= w_prod_nxt[2*W-1:W];
                        r_carry     <= (w_prod_nxt[2*W-1:W] != '0);
                        r_zero      <= (w_prod_nxt == '0);
                        r_neg       <= w_prod_nxt[W-1];
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) r_out_valid <= 1'b0;
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res       = r_res;
    assign bus.res_hi    = r_res_hi;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.ovf       = r_ovf;
    assign o_state       = r_state;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): hand-computed results, latency,
// backpressure and reset-abort checks.
module tb_seq_alu;
    localparam int WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic       clk;
    logic       rst_n;
    logic [1:0] o_state;
    int         n_cmp;
    int         n_fail;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                           input logic c, input logic z, input logic n, input logic v);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".res"},   32'(bus.res),       32'(res));
        chk({tag, ".hi"},    32'(bus.res_hi),    32'(hi));
        chk({tag, ".carry"}, 32'(bus.carry),     32'(c));
        chk({tag, ".zero"},  32'(bus.zero),      32'(z));
        chk({tag, ".neg"},   32'(bus.neg),       32'(n));
        chk({tag, ".ovf"},   32'(bus.ovf),       32'(v));
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = a;
        bus.b        = b;
        for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.opcode   = 3'b000;
        bus.a        = 8'h00;
        bus.b        = 8'h00;
    endtask

    // Waits for out_valid; returns the number of edges counting the accept edge.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!bus.out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".idle"}, 32'(o_state),       32'(ST_IDLE));
    endtask

    initial begin
        int  edges;
        logic seen_valid;
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 3'b000;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.res",       32'(bus.res),       32'd0);
        chk("rst.res_hi",    32'(bus.res_hi),    32'd0);
        chk("rst.flags",     32'({bus.carry, bus.zero, bus.neg, bus.ovf}), 32'd0);
        chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst.state",     32'(o_state),       32'(ST_IDLE));
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);

        send("add1", OP_ADD, 8'd200, 8'd100);
        chk_out("add1", 8'd44, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("add1.busy", 32'(bus.in_ready), 32'd0);
        retire("add1");

        send("add2", OP_ADD, 8'd127, 8'd1);
        chk_out("add2", 8'd128, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        retire("add2");
        send("sub1", OP_SUB, 8'd0, 8'd255);
        chk_out("sub1", 8'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        retire("sub1");
        send("sub2", OP_SUB, 8'd100, 8'd100);
        chk_out("sub2", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        retire("sub2");
        send("sub3", OP_SUB, 8'h80, 8'h01);
        chk_out("sub3", 8'h7F, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        retire("sub3");

        send("mul1", OP_MUL, 8'd255, 8'd255);
        chk("mul1.in_ready", 32'(bus.in_ready), 32'd0);
        chk("mul1.state",    32'(o_state),      32'(ST_MUL));
        wait_valid(edges);
        chk("mul1.latency", 32'(edges), 32'd9);
        chk_out("mul1", 8'd1, 8'd254, 1'b1, 1'b0, 1'b0, 1'b0);
        retire("mul1");
        send("mul2", OP_MUL, 8'd0, 8'd7);
        wait_valid(edges);
        chk("mul2.latency", 32'(edges), 32'd9);
        chk_out("mul2", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        retire("mul2");
        send("mul3", OP_MUL, 8'd16, 8'd16);
        wait_valid(edges);
        chk_out("mul3", 8'd0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        retire("mul3");

        send("shl1", OP_SHL, 8'h81, 8'd1);
        chk_out("shl1", 8'h02, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        retire("shl1");
        send("shr1", OP_SHR, 8'h81, 8'd3);
        chk_out("shr1", 8'h10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        retire("shr1");
        send("shl0", OP_SHL, 8'h81, 8'd0);
        chk_out("shl0", 8'h81, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        retire("shl0");
        send("shr2", OP_SHR, 8'h81, 8'h09);
        chk_out("shr2", 8'h40, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        retire("shr2");
        send("shl7", OP_SHL, 8'h03, 8'd7);
        chk_out("shl7", 8'h80, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        retire("shl7");
        send("xor1", OP_XOR, 8'hFF, 8'h0F);
        chk_out("xor1", 8'hF0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        retire("xor1");
        send("or1", OP_OR, 8'h00, 8'h00);
        chk_out("or1", 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        retire("or1");

        bus.out_ready = 1'b0;
        send("bp", OP_ADD, 8'd10, 8'd20);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_SUB;
        bus.a        = 8'd50;
        bus.b        = 8'd5;
        for (int i = 0; i < 5; i++) begin
            chk_out("bp.hold", 8'd30, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp.state",    32'(o_state),      32'(ST_DONE));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp.idle",      32'(o_state),       32'(ST_IDLE));
        chk("bp.drop",      32'(bus.out_valid), 32'd0);
        chk("bp.kept_res",  32'(bus.res),       32'd30);
        chk("bp.ready",     32'(bus.in_ready),  32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_out("bp.next", 8'd45, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        retire("bp.next");

        send("abort", OP_MUL, 8'd15, 8'd15);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort.res",       32'(bus.res),       32'd0);
        chk("abort.res_hi",    32'(bus.res_hi),    32'd0);
        chk("abort.flags",     32'({bus.carry, bus.zero, bus.neg, bus.ovf}), 32'd0);
        chk("abort.state",     32'(o_state),       32'(ST_IDLE));
        rst_n = 1'b1;
        #1;
        chk("abort.in_ready",  32'(bus.in_ready),  32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("abort.no_result", 32'(seen_valid), 32'd0);

        send("and1", OP_AND, 8'hF0, 8'h3C);
        chk_out("and1", 8'h30, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        retire("and1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
